// File: rtl/fetch_align_ctrl_pkg.sv
// Shared types for the fetch/align front end.
//   fa_state_e : sequencer states (boot, running, redirect bubble)
//   hw_t       : one 16-bit instruction parcel
//   is_rvc()   : a parcel whose low two bits are not 2'b11 starts a 16-bit instruction
//   QDEPTH_HW  : halfword queue depth; a fetch returns up to two parcels
package fetch_align_ctrl_pkg;

  localparam int QDEPTH_HW = 4;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIR
  } fa_state_e;

  typedef logic [15:0] hw_t;

  function automatic logic is_rvc(input hw_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_ctrl_if.sv
// Bundle of the instruction-memory, redirect and decompress-stage signals.
//   master : the fetch controller (drives requests and instructions)
//   slave  : memory / pipeline side (drives responses, redirect, ready)
// Signal names keep their _i/_o suffix as seen from the fetch controller.
interface fetch_align_ctrl_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ins_valid_o;
  logic        ins_ready_i;
  logic [31:0] ins_o;
  logic [31:0] ins_pc_o;
  logic        ins_c_o;

  modport master (
    output imem_req_o, imem_addr_o, ins_valid_o, ins_o, ins_pc_o, ins_c_o,
    input  imem_valid_i, imem_rdata_i, redirect_i, redirect_pc_i, ins_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, ins_valid_o, ins_o, ins_pc_o, ins_c_o,
    output imem_valid_i, imem_rdata_i, redirect_i, redirect_pc_i, ins_ready_i
  );

endinterface

// File: rtl/fetch_align_ctrl_hw_queue.sv
// Four-entry circular buffer of instruction halfwords.
//   clk, rst        : clock, synchronous active-high reset
//   clr             : synchronous flush (same effect as rst on pointers/count)
//   push_n, push_d0 : number of parcels to append (0..2); d0 is written first
//   push_d1           second parcel, used only when push_n == 2
//   pop_n           : number of parcels to drop from the head (0..2)
//   head0, head1    : oldest and second-oldest parcel
//   count           : parcels currently held (0..4)
// The caller guarantees pops never exceed count and count+push-pop never exceeds 4.
module fetch_align_ctrl_hw_queue
  import fetch_align_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] push_n,
  input  hw_t        push_d0,
  input  hw_t        push_d1,
  input  logic [1:0] pop_n,
  output hw_t        head0,
  output hw_t        head1,
  output logic [2:0] count
);

  localparam int PTR_W = $clog2(QDEPTH_HW);
  localparam int CNT_W = PTR_W + 1;

  hw_t              mem [QDEPTH_HW];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage has no reset: the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr] <= push_d0;
    if (push_n == 2'd2) mem[wr_ptr + PTR_W'(1)] <= push_d1;
  end

  // Pointer and occupancy bookkeeping; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/fetch_align_ctrl.sv
// Fetch sequencer between instruction memory and the RVC decompressor.
// Issues word-aligned fetches (one outstanding, one-cycle memory latency),
// buffers returned halfwords and hands one instruction per transfer downstream:
// 16-bit parcels zero-extended, 32-bit ones assembled from two parcels, which
// may come from different fetch words.
//   clk, rst          : clock, synchronous active-high reset
//   bus.imem_req_o    : fetch the word at bus.imem_addr_o (word aligned)
//   bus.imem_valid_i  : bus.imem_rdata_i answers the previous cycle's request
//   bus.redirect_i    : flush and restart at bus.redirect_pc_i
//   bus.ins_valid_o   : bus.ins_o / ins_pc_o / ins_c_o hold an instruction
//   bus.ins_ready_i   : downstream accepts (transfer = valid & ready)
module fetch_align_ctrl
  import fetch_align_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  fetch_align_ctrl_if.master bus
);

  fa_state_e   state;
  logic        outstanding;
  logic        epoch;
  logic        req_epoch;
  logic        drop_lo;
  logic [31:0] fpc;
  logic [31:0] pc;

  hw_t         q_head0;
  hw_t         q_head1;
  logic [2:0]  q_count;
  logic [1:0]  push_n;
  logic [1:0]  pop_n;
  hw_t         push_d0;
  hw_t         push_d1;

  logic        head_c;
  logic        have_ins;
  logic        ins_valid;
  logic        transfer;
  logic        rsp_accept;
  logic        fetch_req;
  logic [2:0]  count_after_pop;

  fetch_align_ctrl_hw_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.redirect_i),
    .push_n  (push_n),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .pop_n   (pop_n),
    .head0   (q_head0),
    .head1   (q_head1),
    .count   (q_count)
  );

  // Emit decision, pop size, fetch decision and response acceptance.
  // A fetch is only issued when two parcels of room will exist after this
  // cycle's pop, so the response can always be pushed in full.
  // Requests are held off during a redirect so fpc is only updated once.
  always_comb begin
    head_c          = is_rvc(q_head0);
    have_ins        = head_c ? (q_count >= 3'd1) : (q_count >= 3'd2);
    ins_valid       = (state == S_RUN) && !bus.redirect_i && have_ins;
    transfer        = ins_valid && bus.ins_ready_i;
    pop_n           = transfer ? (head_c ? 2'd1 : 2'd2) : 2'd0;
    count_after_pop = q_count - {1'b0, pop_n};
    fetch_req       = (state == S_RUN) && !bus.redirect_i && !outstanding &&
                      (count_after_pop <= 3'd2);
    // The epoch tag guards against a response belonging to a fetch issued
    // before the last redirect.
    rsp_accept      = bus.imem_valid_i && outstanding && (req_epoch == epoch) &&
                      !bus.redirect_i;
    push_n          = rsp_accept ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
    // When the target PC sits in the upper half of a word, the lower half of
    // the first returned word is not part of the stream.
    push_d0         = drop_lo ? bus.imem_rdata_i[31:16] : bus.imem_rdata_i[15:0];
    push_d1         = bus.imem_rdata_i[31:16];
  end

  // Sequencer state, fetch address, epoch and instruction PC.
  // Redirect overrides everything except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      outstanding <= 1'b0;
      epoch       <= 1'b0;
      req_epoch   <= 1'b0;
      fpc         <= RESET_PC & ~32'h3;
      drop_lo     <= RESET_PC[1];
      pc          <= RESET_PC;
    end else if (bus.redirect_i) begin
      state       <= S_REDIR;
      outstanding <= 1'b0;
      epoch       <= ~epoch;
      fpc         <= bus.redirect_pc_i & ~32'h3;
      drop_lo     <= bus.redirect_pc_i[1];
      pc          <= bus.redirect_pc_i;
    end else begin
      case (state)
        S_BOOT:  state <= S_RUN;
        S_REDIR: state <= S_RUN;
        S_RUN:   state <= S_RUN;
        default: state <= S_BOOT;
      endcase
      if (fetch_req) begin
        outstanding <= 1'b1;
        req_epoch   <= epoch;
        fpc         <= fpc + 32'd4;
      end else if (rsp_accept) begin
        outstanding <= 1'b0;
      end
      if (rsp_accept) drop_lo <= 1'b0;
      if (transfer)   pc <= pc + (head_c ? 32'd2 : 32'd4);
    end
  end

  assign bus.imem_req_o  = fetch_req;
  assign bus.imem_addr_o = fpc;
  assign bus.ins_valid_o = ins_valid;
  assign bus.ins_o       = !ins_valid ? 32'h0 :
                           head_c     ? {16'h0000, q_head0} : {q_head1, q_head0};
  assign bus.ins_pc_o    = pc;
  assign bus.ins_c_o     = ins_valid && head_c;

endmodule
